mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the five-stage MIPS pipeline, directly upstream of the write-back stage.
- Takes EX results and the 18-bit control bundle, and performs loads and stores over a req/ack data-memory port, stalling upstream while an access is outstanding.
- Formats load data, then registers result, destination and control bundle into the MEM/WB outputs consumed by write-back.

Parameters:
- ACK_TIMEOUT, 16, max BUSY cycles waiting for dmem_ack before a bus error is flagged (1..255).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- ex_valid  input  1  EX holds a valid instruction
- ex_ctrl  input  18  control bundle (bit8 rf_enable, bit7 ta_instr, bit1 hi_enable, bit0 lo_enable)
- ex_alu_result  input  32  ALU result / effective address
- ex_store_data  input  32  rt value for stores
- ex_dest  input  5  destination register
- ex_mem_read  input  1  load
- ex_mem_write  input  1  store
- ex_mem_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- ex_mem_signed  input  1  sign-extend load
- dmem_req  output  1  access request
- dmem_we  output  1  write strobe
- dmem_addr  output  32  word address (bits 1:0 forced 0)
- dmem_wdata  output  32  store data, lane-replicated
- dmem_be  output  4  byte enables, big-endian (be[3] = bits 31:24 = addr offset 0)
- dmem_rdata  input  32  read data, valid with ack
- dmem_ack  input  1  access complete
- mem_stall  output  1  upstream must hold ex_* stable
- wb_valid  output  1  MEM/WB valid
- wb_ctrl  output  18  registered control bundle
- wb_result  output  32  load data or ALU result
- wb_dest  output  5  registered destination
- wb_addr_err  output  1  misaligned access
- wb_bus_err  output  1  ack timeout

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, all wb_* outputs, and the timeout counter cleared to 0. A reset in BUSY aborts the access; dmem_req is 0 from the next cycle.
- mem_op = ex_valid & (ex_mem_read | ex_mem_write).
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
- FSM IDLE:
  - Non-mem op: wb_* registered at the next edge (1-cycle latency); mem_stall=0.
  - ex_valid=0: bubble, with wb_valid=0, wb_ctrl=0 and wb_result=0.
  - Misaligned mem op: no request. wb_valid=1, wb_addr_err=1, wb_ctrl=ex_ctrl with bit8 cleared; mem_stall=0.
  - Aligned mem op: mem_stall=1. Register dmem_addr/wdata/be/we, set dmem_req=1, clear the counter, go to BUSY. wb outputs a bubble that edge.
- FSM BUSY:
  - dmem_req and all dmem_* outputs are held.
  - mem_stall = ~dmem_ack & (count != ACK_TIMEOUT-1).
  - On ack: register wb outputs (load: formatted rdata; store: ex_alu_result), set dmem_req=0, go to IDLE. Upstream advances at the same edge.
  - On timeout without ack: wb_valid=1, wb_bus_err=1, ctrl bit8 cleared, dmem_req=0, go to IDLE.
  - Ack wins over timeout in the same cycle.
- Minimum mem-op latency: 2 cycles (IDLE cycle + BUSY with immediate ack).
- An ack while in IDLE is ignored.
- wb_addr_err and wb_bus_err are valid only for one wb_valid beat.
- Store lanes:
  - byte: wdata={4{d[7:0]}}, be=1000>>offset
  - half: wdata={2{d[15:0]}}, be=1100 (offset 0) or 0011 (offset 2)
  - word: be=1111
- Load extraction:
  - byte lane: offset 0 → bits 31:24, offset 3 → bits 7:0
  - half lane: offset 0 → bits 31:16
  - Zero- or sign-extend per ex_mem_signed; word loads pass through unchanged.
- ex_ctrl is passed through unmodified except for the error cases above.

Test Plan:
- ADD: ex_valid=1, no mem, alu=0x00000042, dest=5, ctrl bit8=1 → next edge: wb_valid=1, wb_result=0x42, wb_dest=5, mem_stall=0 throughout.
- LB signed, addr 0x1003, rdata 0x12345680, immediate ack → dmem_addr=0x1000, dmem_req for 1 cycle, wb_result=0xFFFFFF80, total latency 2.
- LHU, addr 0x2002, ack delayed 3 BUSY cycles, rdata 0xAAAA8001 → mem_stall high 4 cycles, wb_result=0x00008001.
- SB, addr 0x3001, data 0x000000AB → dmem_we=1, be=0100, wdata=0xABABABAB.
- LW, addr 0x4002 → no dmem_req, wb_addr_err=1, wb_ctrl bit8=0.
- LW with ACK_TIMEOUT=4 and no ack → wb_bus_err=1 after 4 BUSY cycles, dmem_req=0.
- Reset asserted in BUSY → dmem_req=0 the next cycle, wb_valid=0, FSM in IDLE, and a following ADD completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage of the five-stage MIPS pipeline.
//
// Takes the EX results plus the 18-bit control bundle and performs loads and
// stores over a req/ack data-memory port. While an access is outstanding,
// upstream is held with mem_stall. Load data is lane-extracted and extended.
// The result, destination and control bundle are then registered into the
// MEM/WB outputs.
//
// Parameters:
//   ACK_TIMEOUT   BUSY cycles allowed for dmem_ack before a bus error (1..255)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ex_valid              EX holds a valid instruction
//   ex_ctrl[17:0]         control bundle (bit8 rf_enable, bit7 ta_instr,
//                         bit1 hi_enable, bit0 lo_enable)
//   ex_alu_result[31:0]   ALU result / effective address
//   ex_store_data[31:0]   rt value for stores
//   ex_dest[4:0]          destination register
//   ex_mem_read/write     load / store
//   ex_mem_size[1:0]      00 byte, 01 half, 10 word, 11 treated as word
//   ex_mem_signed         sign-extend load data
//   dmem_req/we/addr/wdata/be   registered data-memory request (big-endian be)
//   dmem_rdata, dmem_ack  memory response
//   mem_stall             upstream must hold ex_* stable
//   wb_valid/ctrl/result/dest/addr_err/bus_err   MEM/WB pipeline register
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [17:0] ex_ctrl,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_dest,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_signed,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [17:0] wb_ctrl,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_dest,
    output logic        wb_addr_err,
    output logic        wb_bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(ACK_TIMEOUT - 1);
    // Error beats must not write the register file.
    localparam logic [17:0] RF_ENABLE_MASK = ~(18'd1 << 8);

    state_t      state_reg;
    logic [7:0]  count_reg;

    logic        mem_op;
    logic        aligned;
    logic [1:0]  offset;
    logic [31:0] store_wdata;
    logic [3:0]  store_be;
    logic [31:0] load_data;
    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);
    assign offset = ex_alu_result[1:0];

    always_comb begin
        case (ex_mem_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~offset[0];
            default: aligned = (offset == 2'b00);
        endcase
    end

    // Store lane placement: data replicated across lanes, enables pick the lane.
    always_comb begin
        case (ex_mem_size)
            2'b00: begin
                store_wdata = {4{ex_store_data[7:0]}};
                store_be    = 4'b1000 >> offset;
            end
            2'b01: begin
                store_wdata = {2{ex_store_data[15:0]}};
                store_be    = offset[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                store_wdata = ex_store_data;
                store_be    = 4'b1111;
            end
        endcase
    end

    // Big-endian byte lanes: lane 0 is bits 31:24.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_byte[gi] = dmem_rdata[31 - 8*gi -: 8];
        end
    endgenerate

    // Load formatting. ex_* is held stable during BUSY, so the offset and
    // size seen at ack time belong to the outstanding access.
    always_comb begin
        sel_byte = rd_byte[offset];
        sel_half = offset[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        case (ex_mem_size)
            2'b00:   load_data = {{24{ex_mem_signed & sel_byte[7]}}, sel_byte};
            2'b01:   load_data = {{16{ex_mem_signed & sel_half[15]}}, sel_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        if (state_reg == IDLE)
            mem_stall = mem_op & aligned;
        else
            mem_stall = ~dmem_ack & (count_reg != LAST_COUNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= 8'd0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'd0;
            dmem_wdata  <= 32'd0;
            dmem_be     <= 4'd0;
            wb_valid    <= 1'b0;
            wb_ctrl     <= 18'd0;
            wb_result   <= 32'd0;
            wb_dest     <= 5'd0;
            wb_addr_err <= 1'b0;
            wb_bus_err  <= 1'b0;
        end else begin
            // Bubble unless a branch below produces a beat; this also keeps the
            // error flags to a single wb_valid beat.
            wb_valid    <= 1'b0;
            wb_ctrl     <= 18'd0;
            wb_result   <= 32'd0;
            wb_dest     <= 5'd0;
            wb_addr_err <= 1'b0;
            wb_bus_err  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (ex_valid && !mem_op) begin
                        wb_valid  <= 1'b1;
                        wb_ctrl   <= ex_ctrl;
                        wb_result <= ex_alu_result;
                        wb_dest   <= ex_dest;
                    end else if (mem_op && !aligned) begin
                        wb_valid    <= 1'b1;
                        wb_ctrl     <= ex_ctrl & RF_ENABLE_MASK;
                        wb_result   <= ex_alu_result;
                        wb_dest     <= ex_dest;
                        wb_addr_err <= 1'b1;
                    end else if (mem_op) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= ex_mem_write;
                        dmem_addr  <= {ex_alu_result[31:2], 2'b00};
                        dmem_wdata <= store_wdata;
                        dmem_be    <= store_be;
                        count_reg  <= 8'd0;
                        state_reg  <= BUSY;
                    end
                end

                BUSY: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (dmem_ack) begin
                        wb_valid  <= 1'b1;
                        wb_ctrl   <= ex_ctrl;
                        wb_result <= ex_mem_read ? load_data : ex_alu_result;
                        wb_dest   <= ex_dest;
                        dmem_req  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (count_reg == LAST_COUNT) begin
                        wb_valid   <= 1'b1;
                        wb_ctrl    <= ex_ctrl & RF_ENABLE_MASK;
                        wb_result  <= ex_alu_result;
                        wb_dest    <= ex_dest;
                        wb_bus_err <= 1'b1;
                        dmem_req   <= 1'b0;
                        state_reg  <= IDLE;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Directed cases followed by randomized operations. Each operation is
// checked against a small word-array memory and arithmetic lane rules.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int ACK_T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [17:0] ex_ctrl;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_signed;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        wb_valid;
    logic [17:0] wb_ctrl;
    logic [31:0] wb_result;
    logic [4:0]  wb_dest;
    logic        wb_addr_err;
    logic        wb_bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_lat;
    int obs_stall;
    logic [31:0] tb_mem [16];

    always #5 clk = ~clk;

    mem_stage #(.ACK_TIMEOUT(ACK_T)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_size(ex_mem_size), .ex_mem_signed(ex_mem_signed),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_result(wb_result),
        .wb_dest(wb_dest), .wb_addr_err(wb_addr_err), .wb_bus_err(wb_bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected load value from a memory word, by plain shift/mask arithmetic.
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input int off);
        logic [31:0] r;
        if (sz == 2'd0) begin
            r = (w >> ((3 - off) * 8)) & 32'hFF;
            if (sg && r > 32'd127) r = r - 32'd256;
        end else if (sz == 2'd1) begin
            r = (w >> ((2 - off) * 8)) & 32'hFFFF;
            if (sg && r > 32'd32767) r = r - 32'd65536;
        end else begin
            r = w;
        end
        return r;
    endfunction

    // One instruction presented at EX; ack_dly = BUSY cycle index of the ack
    // (>= ACK_T means the memory never answers).
    task automatic do_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] dest, input logic [17:0] ctrl, input int ack_dly);
        logic mop, al, done, acked;
        int off, idx;
        logic [31:0] exp_be, exp_wd, exp_res, w, m;
        mop = v && (rd || wr);
        off = int'(addr[1:0]);
        idx = int'(addr[5:2]);
        al  = (sz == 2'd0) ? 1'b1 : (sz == 2'd1) ? (off % 2 == 0) : (off == 0);
        if (sz == 2'd0) begin
            exp_be = 32'd1 << (3 - off);
            exp_wd = (data & 32'hFF) * 32'h01010101;
        end else if (sz == 2'd1) begin
            exp_be = 32'd3 << (2 - off);
            exp_wd = (data & 32'hFFFF) * 32'h00010001;
        end else begin
            exp_be = 32'hF;
            exp_wd = data;
        end

        @(negedge clk);
        ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_mem_size = sz;
        ex_mem_signed = sg; ex_alu_result = addr; ex_store_data = data;
        ex_dest = dest; ex_ctrl = ctrl; dmem_ack = 1'b0;
        #1;
        obs_stall = mem_stall ? 1 : 0;
        check("idle_stall", 32'(mem_stall), 32'(mop && al));
        @(posedge clk); #1;
        obs_lat = 1;
        if (!mop || !al) begin
            check("req_off", 32'(dmem_req), 32'd0);
            check("wb_valid", 32'(wb_valid), 32'(v));
            check("wb_addr_err", 32'(wb_addr_err), 32'(mop));
            check("wb_bus_err", 32'(wb_bus_err), 32'd0);
            if (v) begin
                check("wb_ctrl", 32'(wb_ctrl), 32'(mop ? (ctrl & ~18'h100) : ctrl));
                check("wb_dest", 32'(wb_dest), 32'(dest));
                if (!mop) check("wb_result", wb_result, addr);
            end else begin
                check("bubble_ctrl", 32'(wb_ctrl), 32'd0);
                check("bubble_result", wb_result, 32'd0);
            end
        end else begin
            check("req_on", 32'(dmem_req), 32'd1);
            check("dmem_we", 32'(dmem_we), 32'(wr));
            check("dmem_addr", dmem_addr, addr & ~32'd3);
            check("dmem_be", 32'(dmem_be), exp_be);
            if (wr) check("dmem_wdata", dmem_wdata, exp_wd);
            check("wb_bubble", 32'(wb_valid), 32'd0);
            done = 1'b0;
            for (int k = 0; k < ACK_T && !done; k++) begin
                @(negedge clk);
                acked = (k == ack_dly);
                if (acked) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = tb_mem[idx];
                end else begin
                    dmem_rdata = $urandom;
                end
                #1;
                if (mem_stall) obs_stall++;
                check("busy_stall", 32'(mem_stall), 32'(!acked && k != ACK_T - 1));
                @(posedge clk); #1;
                obs_lat++;
                if (acked || k == ACK_T - 1) begin
                    done = 1'b1;
                    check("req_done", 32'(dmem_req), 32'd0);
                    check("wb_valid", 32'(wb_valid), 32'd1);
                    check("wb_dest", 32'(wb_dest), 32'(dest));
                    check("wb_addr_err", 32'(wb_addr_err), 32'd0);
                    check("wb_bus_err", 32'(wb_bus_err), 32'(!acked));
                    check("wb_ctrl", 32'(wb_ctrl), 32'(acked ? ctrl : (ctrl & ~18'h100)));
                    if (acked) begin
                        exp_res = rd ? fmt_load(tb_mem[idx], sz, sg, off) : addr;
                        check("wb_result", wb_result, exp_res);
                        if (wr) begin
                            w = tb_mem[idx];
                            for (int i = 0; i < 4; i++) begin
                                if (exp_be[3 - i]) begin
                                    m = 32'hFF << ((3 - i) * 8);
                                    w = (w & ~m) | (exp_wd & m);
                                end
                            end
                            tb_mem[idx] = w;
                        end
                    end
                end else begin
                    check("req_hold", 32'(dmem_req), 32'd1);
                    check("wb_wait", 32'(wb_valid), 32'd0);
                end
            end
            dmem_ack = 1'b0;
        end
        $display("op v=%0b rd=%0b wr=%0b sz=%0d sg=%0b addr=%h ack_dly=%0d lat=%0d stall=%0d wb=%h",
                 v, rd, wr, sz, sg, addr, ack_dly, obs_lat, obs_stall, wb_result);
    endtask

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_ctrl = '0; ex_alu_result = '0;
        ex_store_data = '0; ex_dest = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_mem_size = '0; ex_mem_signed = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
        for (int i = 0; i < 16; i++) tb_mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_result", wb_result, 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        @(negedge clk); reset = 1'b0;

        // ADD
        do_op(1, 0, 0, 2'd2, 0, 32'h42, 0, 5'd5, 18'h100, 0);
        check("add_lat", obs_lat, 1);
        check("add_stall", obs_stall, 0);
        check("add_result", wb_result, 32'h42);

        // LB signed, immediate ack
        tb_mem[0] = 32'h12345680;
        do_op(1, 1, 0, 2'd0, 1, 32'h1003, 0, 5'd7, 18'h180, 0);
        check("lb_result", wb_result, 32'hFFFFFF80);
        check("lb_lat", obs_lat, 2);
        check("lb_addr", dmem_addr, 32'h1000);

        // LHU, ack after 3 waiting BUSY cycles
        tb_mem[0] = 32'hAAAA8001;
        do_op(1, 1, 0, 2'd1, 0, 32'h2002, 0, 5'd8, 18'h100, 3);
        check("lhu_stall", obs_stall, 4);
        check("lhu_result", wb_result, 32'h00008001);

        // SB
        do_op(1, 0, 1, 2'd0, 0, 32'h3001, 32'hAB, 5'd0, 18'h000, 0);
        check("sb_we", 32'(dmem_we), 32'd1);
        check("sb_be", 32'(dmem_be), 32'b0100);
        check("sb_wdata", dmem_wdata, 32'hABABABAB);

        // Misaligned LW
        do_op(1, 1, 0, 2'd2, 0, 32'h4002, 0, 5'd9, 18'h3FFFF, 0);
        check("lw_mis_err", 32'(wb_addr_err), 32'd1);
        check("lw_mis_bit8", 32'(wb_ctrl[8]), 32'd0);

        // LW timeout
        do_op(1, 1, 0, 2'd2, 0, 32'h4004, 0, 5'd10, 18'h100, 99);
        check("to_bus_err", 32'(wb_bus_err), 32'd1);
        check("to_lat", obs_lat, 1 + ACK_T);
        check("to_req", 32'(dmem_req), 32'd0);

        // Reset while BUSY
        @(negedge clk);
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_mem_size = 2'd2;
        ex_alu_result = 32'h1004; ex_dest = 5'd3;
        @(posedge clk); #1;
        check("rb_req_on", 32'(dmem_req), 32'd1);
        @(negedge clk); reset = 1'b1; ex_valid = 1'b0;
        @(posedge clk); #1;
        check("rb_req_off", 32'(dmem_req), 32'd0);
        check("rb_wb_valid", 32'(wb_valid), 32'd0);
        check("rb_idle_stall", 32'(mem_stall), 32'd0);
        @(negedge clk); reset = 1'b0;
        do_op(1, 0, 0, 2'd2, 0, 32'h1234, 0, 5'd4, 18'h100, 0);
        check("rb_add_lat", obs_lat, 1);

        // Randomized operations
        for (int n = 0; n < 80; n++) begin
            logic v, rd, wr;
            int kind;
            v = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 2);
            rd = (kind == 1);
            wr = (kind == 2);
            do_op(v, rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'h1000 + 32'($urandom_range(0, 63)), $urandom,
                  5'($urandom_range(0, 31)), 18'($urandom), $urandom_range(0, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
